// File: rtl/nixie_pkg.sv
// Shared definitions for the nixie/7-segment display path:
// segment codes, segment bit positions, frame FSM states.
package nixie_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_CODE_0 = 7'h3F;
    localparam logic [6:0] SEG_CODE_1 = 7'h06;
    localparam logic [6:0] SEG_CODE_2 = 7'h5B;
    localparam logic [6:0] SEG_CODE_3 = 7'h4F;
    localparam logic [6:0] SEG_CODE_4 = 7'h66;
    localparam logic [6:0] SEG_CODE_5 = 7'h6D;
    localparam logic [6:0] SEG_CODE_6 = 7'h7D;
    localparam logic [6:0] SEG_CODE_7 = 7'h07;
    localparam logic [6:0] SEG_CODE_8 = 7'h7F;
    localparam logic [6:0] SEG_CODE_9 = 7'h6F;
    localparam logic [6:0] SEG_CODE_A = 7'h77;
    localparam logic [6:0] SEG_CODE_B = 7'h7C;
    localparam logic [6:0] SEG_CODE_C = 7'h39;
    localparam logic [6:0] SEG_CODE_D = 7'h5E;
    localparam logic [6:0] SEG_CODE_E = 7'h79;
    localparam logic [6:0] SEG_CODE_F = 7'h71;
    localparam logic [6:0] SEG_BLANK  = 7'h00;

    typedef enum logic {
        SEEK0,
        SEEK1
    } frame_state_t;

    typedef struct packed {
        logic       ok;
        logic       blank;
        logic [3:0] value;
    } seg_dec_t;

endpackage

// File: rtl/nixie_scan_decoder_seg7_decode.sv
// Combinational 7-segment pattern (a..g, active-high) to hex value.
// Unknown patterns report ok=0; all-dark reports blank with value 0.
module seg7_decode
    import nixie_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   dec
);

    always_comb begin
        dec = '{ok: 1'b1, blank: 1'b0, value: 4'h0};
        unique case (pattern)
            SEG_CODE_0: dec.value = 4'h0;
            SEG_CODE_1: dec.value = 4'h1;
            SEG_CODE_2: dec.value = 4'h2;
            SEG_CODE_3: dec.value = 4'h3;
            SEG_CODE_4: dec.value = 4'h4;
            SEG_CODE_5: dec.value = 4'h5;
            SEG_CODE_6: dec.value = 4'h6;
            SEG_CODE_7: dec.value = 4'h7;
            SEG_CODE_8: dec.value = 4'h8;
            SEG_CODE_9: dec.value = 4'h9;
            SEG_CODE_A: dec.value = 4'hA;
            SEG_CODE_B: dec.value = 4'hB;
            SEG_CODE_C: dec.value = 4'hC;
            SEG_CODE_D: dec.value = 4'hD;
            SEG_CODE_E: dec.value = 4'hE;
            SEG_CODE_F: dec.value = 4'hF;
            SEG_BLANK:  dec.blank = 1'b1;
            default:    dec.ok    = 1'b0;
        endcase
    end

endmodule

// File: rtl/nixie_scan_decoder.sv
// Decodes a scanned two-digit SEG/COM display back into digit values.
// Optional NIXIE_DEC_FRAME_COUNT_EN adds the Frame_Cnt output.
module nixie_scan_decoder
    import nixie_pkg::*;
#(
    parameter int STABLE_CNT     = 8,
    parameter int TIMEOUT        = 2500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int COM_ACTIVE_LOW = 1
) (
    input  logic        Sys_CLK,
    input  logic        Sys_RST,
    input  logic        Sample_EN,
    input  logic [7:0]  SEG,
    input  logic [1:0]  COM,
    output logic [3:0]  Digit0,
    output logic [3:0]  Digit1,
    output logic [1:0]  DP,
    output logic [1:0]  Blank,
    output logic        Valid,
    output logic        Err,
    output logic        Stale
`ifdef NIXIE_DEC_FRAME_COUNT_EN
    ,
    output logic [15:0] Frame_Cnt
`endif
);

    localparam logic [7:0]  STAB_MAX = 8'(STABLE_CNT - 1);
    localparam logic [7:0]  STAB_ARM = 8'(STABLE_CNT - 2);
    localparam logic [15:0] TO_MAX   = 16'(TIMEOUT);

    logic [7:0]   seg_n;
    logic [1:0]   com_n;
    logic [9:0]   prev;
    logic [7:0]   stab_cnt;
    logic [15:0]  to_cnt;
    logic         qual;
    logic         same;
    logic         accept;
    logic         good;
    logic         bad;
    logic         is_d1;
    seg_dec_t     dec;
    frame_state_t state;
    frame_state_t state_nx;
    logic         ld0;
    logic         publish;
    logic [3:0]   sh0_val;
    logic         sh0_dp;
    logic         sh0_blank;

    assign seg_n = (SEG_ACTIVE_LOW != 0) ? ~SEG : SEG;
    assign com_n = (COM_ACTIVE_LOW != 0) ? ~COM : COM;
    assign qual  = (com_n == 2'b01) || (com_n == 2'b10);
    assign same  = ({com_n, seg_n} == prev);
    assign is_d1 = com_n[1];

    // Fires exactly once, on the sample that brings the run to STABLE_CNT.
    assign accept = Sample_EN && same && qual && (stab_cnt == STAB_ARM);
    assign good   = accept && dec.ok;
    assign bad    = accept && !dec.ok;

    seg7_decode u_dec (
        .pattern (seg_n[SEG_G:SEG_A]),
        .dec     (dec)
    );

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            prev     <= '0;
            stab_cnt <= '0;
        end else if (Sample_EN) begin
            prev <= {com_n, seg_n};
            if (same && qual) begin
                if (stab_cnt != STAB_MAX)
                    stab_cnt <= stab_cnt + 8'd1;
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST)
            to_cnt <= '0;
        else if (accept)
            to_cnt <= '0;
        else if (Sample_EN && to_cnt != TO_MAX)
            to_cnt <= to_cnt + 16'd1;
    end

    assign Stale = (to_cnt == TO_MAX);

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST)
            state <= SEEK0;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld0      = 1'b0;
        publish  = 1'b0;
        if (good) begin
            unique case (state)
                SEEK0: begin
                    if (!is_d1) begin
                        ld0      = 1'b1;
                        state_nx = SEEK1;
                    end
                end
                SEEK1: begin
                    if (is_d1) begin
                        publish  = 1'b1;
                        state_nx = SEEK0;
                    end else begin
                        ld0 = 1'b1;
                    end
                end
            endcase
        end
    end

    // Digit1 goes straight from the decoder to the outputs on publish.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            sh0_val   <= '0;
            sh0_dp    <= 1'b0;
            sh0_blank <= 1'b0;
            Digit0    <= '0;
            Digit1    <= '0;
            DP        <= '0;
            Blank     <= '0;
            Valid     <= 1'b0;
            Err       <= 1'b0;
        end else begin
            Valid <= publish;
            Err   <= bad;
            if (ld0) begin
                sh0_val   <= dec.value;
                sh0_dp    <= seg_n[SEG_DP];
                sh0_blank <= dec.blank;
            end
            if (publish) begin
                Digit0 <= sh0_val;
                Digit1 <= dec.value;
                DP     <= {seg_n[SEG_DP], sh0_dp};
                Blank  <= {dec.blank, sh0_blank};
            end
        end
    end

`ifdef NIXIE_DEC_FRAME_COUNT_EN
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST)
            Frame_Cnt <= '0;
        else if (publish)
            Frame_Cnt <= Frame_Cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_nixie_scan_decoder.sv
// Directed-vector bench for nixie_scan_decoder (STABLE_CNT=8, TIMEOUT=16).
// Frame_Cnt is checked when NIXIE_DEC_FRAME_COUNT_EN is defined.
module tb_nixie_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [7:0]  seg = 8'hFF;
    logic [1:0]  com = 2'b11;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [1:0]  dp;
    logic [1:0]  blank;
    logic        valid;
    logic        err;
    logic        stale;
`ifdef NIXIE_DEC_FRAME_COUNT_EN
    logic [15:0] fcnt;
`endif

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    nixie_scan_decoder #(
        .STABLE_CNT     (8),
        .TIMEOUT        (16),
        .SEG_ACTIVE_LOW (1),
        .COM_ACTIVE_LOW (1)
    ) dut (
        .Sys_CLK   (clk),
        .Sys_RST   (rst),
        .Sample_EN (en),
        .SEG       (seg),
        .COM       (com),
        .Digit0    (d0),
        .Digit1    (d1),
        .DP        (dp),
        .Blank     (blank),
        .Valid     (valid),
        .Err       (err),
        .Stale     (stale)
`ifdef NIXIE_DEC_FRAME_COUNT_EN
        ,
        .Frame_Cnt (fcnt)
`endif
    );

    always @(negedge clk) begin
        if (valid) valid_cnt++;
        if (err)   err_cnt++;
    end

    task automatic hold(input logic [1:0] c, input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            com = c;
            seg = s;
            en  = 1'b1;
            @(negedge clk);
            en  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        com = 2'b10;
        seg = ~8'h06;
        repeat (3) @(negedge clk);
        checks++;
        if ({d0, d1, dp, blank} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 000", {d0, d1, dp, blank});
        end
        checks++;
        if ({valid, err, stale} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000", {valid, err, stale});
        end
        checks++;
        if (valid_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_valid got %0d exp 0", valid_cnt);
        end
`ifdef NIXIE_DEC_FRAME_COUNT_EN
        checks++;
        if (fcnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt got %0d exp 0", fcnt);
        end
`endif
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame();
        int v0;
        v0 = valid_cnt;
        hold(2'b10, ~8'h06, 8);
        hold(2'b01, ~8'h5B, 7);
        checks++;
        if (valid_cnt - v0 !== 0) begin
            errors++;
            $display("FAIL frame_early_valid got %0d exp 0", valid_cnt - v0);
        end
        hold(2'b01, ~8'h5B, 1);
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL frame_valid got %0d exp 1", valid_cnt - v0);
        end
        checks++;
        if ({d0, d1, dp, blank} !== {4'h1, 4'h2, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL frame_12 got %h exp 120", {d0, d1, dp, blank});
        end
    endtask

    task automatic test_dp_blank();
        hold(2'b10, ~8'h80, 8);
        hold(2'b01, ~8'h71, 8);
        checks++;
        if ({d0, d1, dp, blank} !== {4'h0, 4'hF, 2'b01, 2'b01}) begin
            errors++;
            $display("FAIL blank_dp0 got %h exp 0f5", {d0, d1, dp, blank});
        end
        hold(2'b10, ~8'h6F, 8);
        hold(2'b01, ~8'hF7, 8);
        checks++;
        if ({d0, d1, dp, blank} !== {4'h9, 4'hA, 2'b10, 2'b00}) begin
            errors++;
            $display("FAIL dp1_9a got %h exp 9a8", {d0, d1, dp, blank});
        end
    endtask

    task automatic test_debounce();
        int v0;
        v0 = valid_cnt;
        hold(2'b10, ~8'h06, 7);
        hold(2'b10, ~8'h5B, 3);
        hold(2'b01, ~8'h4F, 8);
        checks++;
        if (valid_cnt - v0 !== 0) begin
            errors++;
            $display("FAIL debounce_valid got %0d exp 0", valid_cnt - v0);
        end
        checks++;
        if ({d0, d1} !== 8'h9A) begin
            errors++;
            $display("FAIL debounce_hold got %h exp 9a", {d0, d1});
        end
    endtask

    task automatic test_invalid();
        int v0;
        int e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        hold(2'b10, ~8'h01, 8);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL invalid_err got %0d exp 1", err_cnt - e0);
        end
        hold(2'b10, ~8'h01, 4);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL invalid_refire got %0d exp 1", err_cnt - e0);
        end
        checks++;
        if (valid_cnt - v0 !== 0 || d0 !== 4'h9) begin
            errors++;
            $display("FAIL invalid_hold got v=%0d d0=%h exp v=0 d0=9",
                     valid_cnt - v0, d0);
        end
    endtask

    task automatic test_stall();
        do_reset();
        hold(2'b00, ~8'h06, 15);
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL stall_15 got %b exp 0", stale);
        end
        hold(2'b00, ~8'h06, 1);
        checks++;
        if (stale !== 1'b1) begin
            errors++;
            $display("FAIL stall_16 got %b exp 1", stale);
        end
        hold(2'b10, ~8'h66, 7);
        checks++;
        if (stale !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got %b exp 1", stale);
        end
        hold(2'b10, ~8'h66, 1);
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL stall_clear got %b exp 0", stale);
        end
    endtask

    task automatic test_midframe_reset();
        int v0;
        hold(2'b01, ~8'h3F, 2);
        do_reset();
        v0 = valid_cnt;
        hold(2'b10, ~8'h07, 8);
        do_reset();
        checks++;
        if ({d0, d1, valid, stale} !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_out got %h exp 0", {d0, d1, valid, stale});
        end
        hold(2'b01, ~8'h4F, 8);
        checks++;
        if (valid_cnt - v0 !== 0) begin
            errors++;
            $display("FAIL mid_reset_discard got %0d exp 0", valid_cnt - v0);
        end
        hold(2'b10, ~8'h6D, 8);
        hold(2'b01, ~8'h4F, 8);
        checks++;
        if (valid_cnt - v0 !== 1 || {d0, d1} !== 8'h53) begin
            errors++;
            $display("FAIL mid_reset_frame got v=%0d d=%h exp v=1 d=53",
                     valid_cnt - v0, {d0, d1});
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_cnt;
        hold(2'b10, ~8'h66, 8);
        hold(2'b10, ~8'h7F, 8);
        hold(2'b01, ~8'h79, 8);
        checks++;
        if (valid_cnt - v0 !== 1 || {d0, d1} !== 8'h8E) begin
            errors++;
            $display("FAIL overwrite got v=%0d d=%h exp v=1 d=8e",
                     valid_cnt - v0, {d0, d1});
        end
`ifdef NIXIE_DEC_FRAME_COUNT_EN
        checks++;
        if (fcnt !== 16'd2) begin
            errors++;
            $display("FAIL frame_cnt got %0d exp 2", fcnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_dp_blank();
        test_debounce();
        test_invalid();
        test_stall();
        test_midframe_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nixie_scan_decoder.md
Name: nixie_scan_decoder

Overview:
- Receive-side counterpart of the two-digit multiplexed 7-segment display driver.
- Samples the scanned SEG/COM lines, waits for each digit's pattern to settle, and decodes it back to a 4-bit value.
- Assembles both digits into a frame and flags undecodable patterns and a stalled scan.
- Used as an on-board loopback monitor and as a bench checker for the display path.

Parameters:
- STABLE_CNT, 8: consecutive identical samples required before a digit is accepted (range 2..255).
- TIMEOUT, 2500: samples without any accepted digit before Stale asserts (range 1..65535).
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its line is 0.
- COM_ACTIVE_LOW, 1: 1 = digit selected when its COM line is 0.

Ports:
- Sys_CLK  input  1  system clock
- Sys_RST  input  1  synchronous, active-high reset
- Sample_EN  input  1  single-cycle sample strobe (one pulse per divided-clock period); all state holds while low
- SEG  input  8  segment lines; bit0..6 = a..g, bit7 = dp
- COM  input  2  digit selects; COM[0] = digit0, COM[1] = digit1
- Digit0  output  4  decoded value of digit0 from the last complete frame
- Digit1  output  4  decoded value of digit1 from the last complete frame
- DP  output  2  decimal-point state per digit, last complete frame
- Blank  output  2  digit was fully dark, last complete frame
- Valid  output  1  one-cycle pulse when a frame completes
- Err  output  1  one-cycle pulse when a stable pattern is not in the decode table
- Stale  output  1  level; no digit accepted for TIMEOUT samples

Behaviour:
- Reset (Sys_RST high at a Sys_CLK edge): all outputs 0, stability counter 0, stale counter 0, shadow registers cleared, FSM to SEEK0. Reset mid-frame discards any partially captured frame.
- Input normalisation: polarity parameters map SEG/COM to active-high internally. A sample is qualified only when exactly one COM bit is active. COM = none or both active: stability counter clears, nothing is captured.
- Stability: on each Sample_EN, compare {COM,SEG} with the previous sample.
  - Equal and qualified: counter increments, saturating at STABLE_CNT-1.
  - Otherwise: counter clears to 0.
  - Acceptance fires once, on the sample where the counter reaches STABLE_CNT-1 (i.e. STABLE_CNT equal samples). No re-fire until the pattern changes.
- Decode (segments a..g): 0-9 and A-F use the standard hex codes; all segments off = blank, value 0, Blank bit set. dp passes through to DP.
- Undecodable pattern at acceptance: Err pulses on the next cycle, the shadow register is unchanged, and the FSM does not advance.
- Frame FSM:
  - SEEK0: acceptance of digit0 → store shadow0, go to SEEK1. Acceptance of digit1 → ignored.
  - SEEK1: acceptance of digit1 → store shadow1; copy both shadows to the outputs; Valid pulses; go to SEEK0. Acceptance of digit0 → overwrite shadow0, stay in SEEK1.
- Latency: Valid and the updated outputs appear one Sys_CLK cycle after the qualifying Sample_EN cycle. Outputs hold until the next frame.
- Stale counter: increments per Sample_EN, saturating at TIMEOUT, and clears on any acceptance (valid or Err). Stale = (counter == TIMEOUT). Acceptance and saturation on the same sample: the clear wins.
- Sample_EN and Sys_RST high together: reset wins.

Optional Feature:
- Macro NIXIE_DEC_FRAME_COUNT_EN.
- Defined: adds output Frame_Cnt [15:0], which increments on every Valid, wraps 16'hFFFF→0, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package nixie_pkg holds:
  - segment-code constants for 0-F and blank, shared with the display driver;
  - the FSM state encoding (SEEK0, SEEK1);
  - segment bit-index constants.
- One natural sub-module, seg7_decode: combinational 7-bit pattern → {valid, blank, value[3:0]}, instantiated once on the selected sample.

Test Plan:
- Reset: assert Sys_RST for 3 cycles → all outputs 0, Stale 0, no Valid.
- Frame decode (active-low polarity):
  - Stimulus: COM=2'b10, SEG=~8'h06 for 8 samples, then COM=2'b01, SEG=~8'h5B for 8 samples.
  - Response: a single Valid pulse; Digit0=1, Digit1=2, DP=0, Blank=0.
- Debounce: hold COM=2'b10, SEG=~8'h06 for 7 samples, then change SEG → no acceptance, FSM stays in SEEK0, no Valid.
- Invalid pattern: COM=2'b10, SEG=~8'h01 held for 8 samples → one Err pulse, no Valid, Digit0 unchanged.
- Stall: COM=2'b00 held, TIMEOUT=16 → Stale rises on sample 16. A subsequent valid digit0 acceptance drops Stale.
- Mid-frame reset: capture digit0=7, pulse Sys_RST, then capture digit1=3 → no Valid. Digit0=5 then digit1=3 → Valid with Digit0=5, Digit1=3.
